// File: rtl/lc3_pkg.sv
// lc3_pkg -- shared definitions for the LC-3 register file / scoreboard slice.
//   LC3_DATA_W : default register width
//   NZP_*      : condition-code encodings {N,Z,P}
//   nzp_of()   : condition code for a value given its sign bit and zero test
package lc3_pkg;

  localparam int LC3_DATA_W = 16;

  localparam logic [2:0] NZP_N     = 3'b100;
  localparam logic [2:0] NZP_Z     = 3'b010;
  localparam logic [2:0] NZP_P     = 3'b001;
  localparam logic [2:0] NZP_RESET = NZP_Z;

  function automatic logic [2:0] nzp_of(input logic neg, input logic zero);
    if (neg)  return NZP_N;
    if (zero) return NZP_Z;
    return NZP_P;
  endfunction

endpackage

// File: rtl/lc3_scoreboard.sv
// lc3_scoreboard -- one busy bit per destination register.
//   i_clock, i_reset_n        : clock, async active-low reset
//   i_rd_addr_a/b             : source addresses to report busy status for
//   i_rsv_valid, i_rsv_addr   : reservation request
//   i_wr_valid, i_wr_addr     : write-back strobe / register
//   o_rsv_ready               : reservation accepted this cycle (combinational)
//   o_rd_busy_a/b             : source register still pending (combinational)
//   o_wr_unrsv                : write-back this cycle targets an unreserved register
module lc3_scoreboard
  import lc3_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic [ADDR_W-1:0] i_rd_addr_a,
  input  logic [ADDR_W-1:0] i_rd_addr_b,
  input  logic              i_rsv_valid,
  input  logic [ADDR_W-1:0] i_rsv_addr,
  input  logic              i_wr_valid,
  input  logic [ADDR_W-1:0] i_wr_addr,
  output logic              o_rsv_ready,
  output logic              o_rd_busy_a,
  output logic              o_rd_busy_b,
  output logic              o_wr_unrsv
);

  localparam logic [ADDR_W:0] LP_NREGS = (ADDR_W+1)'(NUM_REGS);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < LP_NREGS;
  endfunction

  function automatic logic bit_at(input logic [NUM_REGS-1:0] v, input logic [ADDR_W-1:0] a);
    return in_range(a) ? v[a] : 1'b0;
  endfunction

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic                w_wr_hit;
  logic                w_rsv_fire;

  assign w_wr_hit    = i_wr_valid && in_range(i_wr_addr);
  // A register being written back this cycle is free for a new reservation.
  assign o_rsv_ready = in_range(i_rsv_addr) &&
                       (!r_busy[i_rsv_addr] || (w_wr_hit && i_wr_addr == i_rsv_addr));
  assign w_rsv_fire  = i_rsv_valid && o_rsv_ready;
  assign o_wr_unrsv  = i_wr_valid && !bit_at(r_busy, i_wr_addr);

  // Write-back clears first, then an accepted reservation sets, so a
  // same-register collision leaves the bit set.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_wr_hit   && i_wr_addr  == ADDR_W'(i)) w_busy_nxt[i] = 1'b0;
      if (w_rsv_fire && i_rsv_addr == ADDR_W'(i)) w_busy_nxt[i] = 1'b1;
    end
  end

  // Busy is reported only if the bit is set now and stays set: a write-back
  // in flight releases the source early unless it is re-reserved this cycle.
  assign o_rd_busy_a = bit_at(r_busy, i_rd_addr_a) && bit_at(w_busy_nxt, i_rd_addr_a);
  assign o_rd_busy_b = bit_at(r_busy, i_rd_addr_b) && bit_at(w_busy_nxt, i_rd_addr_b);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_busy <= '0;
    else            r_busy <= w_busy_nxt;
  end

endmodule

// File: rtl/lc3_regfile_sb.sv
// lc3_regfile_sb -- LC-3 general register file with reservation scoreboard.
//   i_clock, i_reset_n         : clock, async active-low reset
//   i_rd_addr_a/b, o_rd_data_a/b : two combinational read ports (optional write bypass)
//   o_rd_busy_a/b              : source register has a pending reservation
//   i_rsv_valid/i_rsv_addr, o_rsv_ready : destination reservation handshake
//   i_wr_valid/i_wr_addr/i_wr_data/i_wr_setcc : write-back port
//   o_nzp                      : registered condition codes {N,Z,P}
//   o_wr_err                   : sticky, set by a write-back to an unreserved register
//   i_dbg_addr, o_dbg_data     : registered debug read, one-cycle latency
module lc3_regfile_sb
  import lc3_pkg::*;
#(
  parameter  int DATA_W   = LC3_DATA_W,
  parameter  int NUM_REGS = 8,
  parameter  int BYPASS   = 1,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic [ADDR_W-1:0] i_rd_addr_a,
  input  logic [ADDR_W-1:0] i_rd_addr_b,
  output logic [DATA_W-1:0] o_rd_data_a,
  output logic [DATA_W-1:0] o_rd_data_b,
  output logic              o_rd_busy_a,
  output logic              o_rd_busy_b,
  input  logic              i_rsv_valid,
  input  logic [ADDR_W-1:0] i_rsv_addr,
  output logic              o_rsv_ready,
  input  logic              i_wr_valid,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_setcc,
  output logic [2:0]        o_nzp,
  output logic              o_wr_err,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data
);

  localparam logic [ADDR_W:0] LP_NREGS = (ADDR_W+1)'(NUM_REGS);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < LP_NREGS;
  endfunction

  logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;
  logic [2:0]                      r_nzp;
  logic                            r_wr_err;
  logic [DATA_W-1:0]               r_dbg_data;

  logic w_wr_hit;
  logic w_wr_unrsv;
  logic w_byp_a;
  logic w_byp_b;

  assign w_wr_hit = i_wr_valid && in_range(i_wr_addr);

  lc3_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_sb (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
    .i_rd_addr_a (i_rd_addr_a),
    .i_rd_addr_b (i_rd_addr_b),
    .i_rsv_valid (i_rsv_valid),
    .i_rsv_addr  (i_rsv_addr),
    .i_wr_valid  (i_wr_valid),
    .i_wr_addr   (i_wr_addr),
    .o_rsv_ready (o_rsv_ready),
    .o_rd_busy_a (o_rd_busy_a),
    .o_rd_busy_b (o_rd_busy_b),
    .o_wr_unrsv  (w_wr_unrsv)
  );

  // Forward only writes that will actually land in the array.
  assign w_byp_a = (BYPASS != 0) && w_wr_hit && (i_wr_addr == i_rd_addr_a);
  assign w_byp_b = (BYPASS != 0) && w_wr_hit && (i_wr_addr == i_rd_addr_b);

  assign o_rd_data_a = w_byp_a ? i_wr_data :
                       (in_range(i_rd_addr_a) ? r_regs[i_rd_addr_a] : '0);
  assign o_rd_data_b = w_byp_b ? i_wr_data :
                       (in_range(i_rd_addr_b) ? r_regs[i_rd_addr_b] : '0);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_regs     <= '0;
      r_nzp      <= NZP_RESET;
      r_wr_err   <= 1'b0;
      r_dbg_data <= '0;
    end else begin
      // Samples the pre-write array contents.
      r_dbg_data <= in_range(i_dbg_addr) ? r_regs[i_dbg_addr] : '0;
      if (w_wr_hit)
        r_regs[i_wr_addr] <= i_wr_data;
      if (i_wr_valid && i_wr_setcc)
        r_nzp <= nzp_of(i_wr_data[DATA_W-1], i_wr_data == '0);
      if (w_wr_unrsv)
        r_wr_err <= 1'b1;
    end
  end

  assign o_nzp      = r_nzp;
  assign o_wr_err   = r_wr_err;
  assign o_dbg_data = r_dbg_data;

endmodule

// File: tb/tb_lc3_regfile_sb.sv
module tb_lc3_regfile_sb;
  localparam int DW = 16;
  localparam int NR = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] rd_a = '0, rd_b = '0, rsv_addr = '0, wr_addr = '0, dbg_addr = '0;
  logic          rsv_valid = 1'b0, wr_valid = 1'b0, wr_setcc = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] rdd_a, rdd_b, dbg_data;
  logic          busy_a, busy_b, rsv_ready, wr_err;
  logic [2:0]    nzp;

  always #5 clk = ~clk;

  lc3_regfile_sb #(.DATA_W(DW), .NUM_REGS(NR), .BYPASS(1)) dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_rd_addr_a(rd_a), .i_rd_addr_b(rd_b),
    .o_rd_data_a(rdd_a), .o_rd_data_b(rdd_b),
    .o_rd_busy_a(busy_a), .o_rd_busy_b(busy_b),
    .i_rsv_valid(rsv_valid), .i_rsv_addr(rsv_addr), .o_rsv_ready(rsv_ready),
    .i_wr_valid(wr_valid), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_setcc(wr_setcc),
    .o_nzp(nzp), .o_wr_err(wr_err),
    .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [DW-1:0] m_regs [NR];
  bit            m_busy [NR];
  logic [2:0]    m_nzp;
  bit            m_err;
  logic [DW-1:0] m_dbg;

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin m_regs[i] = '0; m_busy[i] = 0; end
    m_nzp = 3'b010; m_err = 0; m_dbg = '0;
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    return (wr_valid && wr_addr == a) ? wr_data : m_regs[a];
  endfunction

  function automatic logic exp_ready();
    return !m_busy[rsv_addr] || (wr_valid && wr_addr == rsv_addr);
  endfunction

  // Busy unless being written this cycle without being re-reserved.
  function automatic logic exp_busy(input logic [AW-1:0] a);
    logic wr_here, rsv_here;
    wr_here  = wr_valid && wr_addr == a;
    rsv_here = rsv_valid && exp_ready() && rsv_addr == a;
    return m_busy[a] && !(wr_here && !rsv_here);
  endfunction

  task automatic model_edge();
    logic fire;
    logic [DW-1:0] old;
    fire = rsv_valid && exp_ready();
    old  = m_regs[dbg_addr];
    if (wr_valid) begin
      if (!m_busy[wr_addr]) m_err = 1;
      m_regs[wr_addr] = wr_data;
      m_busy[wr_addr] = 0;
      if (wr_setcc) m_nzp = wr_data[DW-1] ? 3'b100 : (wr_data == 0 ? 3'b010 : 3'b001);
    end
    if (fire) m_busy[rsv_addr] = 1;
    m_dbg = old;
  endtask

  task automatic idle();
    rsv_valid = 0; wr_valid = 0; wr_setcc = 0; wr_data = '0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic rv; logic [2:0] ra; logic wv; logic [2:0] wa; logic [15:0] wd; logic sc;
    logic [2:0] rda; logic [2:0] dbg;
    logic [15:0] e_rd; logic e_busy; logic e_rdy; logic [2:0] e_nzp; logic e_err; logic [15:0] e_dbg;
  } vec_t;
  vec_t tbl [11];

  initial begin
    tbl[0]  = '{1'b1,3'd3,1'b0,3'd0,16'h0000,1'b0,3'd3,3'd3, 16'h0000,1'b0,1'b1,3'b010,1'b0,16'h0000};
    tbl[1]  = '{1'b0,3'd3,1'b1,3'd3,16'h8001,1'b1,3'd3,3'd3, 16'h8001,1'b0,1'b1,3'b100,1'b0,16'h0000};
    tbl[2]  = '{1'b1,3'd2,1'b0,3'd0,16'h0000,1'b0,3'd3,3'd3, 16'h8001,1'b0,1'b1,3'b100,1'b0,16'h8001};
    tbl[3]  = '{1'b0,3'd2,1'b1,3'd2,16'h0000,1'b1,3'd2,3'd2, 16'h0000,1'b0,1'b1,3'b010,1'b0,16'h0000};
    tbl[4]  = '{1'b1,3'd5,1'b0,3'd0,16'h0000,1'b0,3'd5,3'd0, 16'h0000,1'b0,1'b1,3'b010,1'b0,16'h0000};
    tbl[5]  = '{1'b1,3'd5,1'b0,3'd0,16'h0000,1'b0,3'd5,3'd0, 16'h0000,1'b1,1'b0,3'b010,1'b0,16'h0000};
    tbl[6]  = '{1'b1,3'd5,1'b1,3'd5,16'h1234,1'b0,3'd5,3'd5, 16'h1234,1'b1,1'b1,3'b010,1'b0,16'h0000};
    tbl[7]  = '{1'b0,3'd5,1'b0,3'd0,16'h0000,1'b0,3'd5,3'd5, 16'h1234,1'b1,1'b0,3'b010,1'b0,16'h1234};
    tbl[8]  = '{1'b0,3'd1,1'b1,3'd1,16'h0007,1'b0,3'd1,3'd1, 16'h0007,1'b0,1'b1,3'b010,1'b1,16'h0000};
    tbl[9]  = '{1'b0,3'd5,1'b1,3'd5,16'h0042,1'b1,3'd1,3'd1, 16'h0007,1'b0,1'b1,3'b001,1'b1,16'h0007};
    tbl[10] = '{1'b0,3'd0,1'b0,3'd0,16'h0000,1'b0,3'd5,3'd5, 16'h0042,1'b0,1'b1,3'b001,1'b1,16'h0042};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int a = 0; a < NR; a++) begin
      rd_a = AW'(a); rd_b = AW'(NR-1-a);
      #1;
      chk("reset_rd_a", rdd_a, 0);  chk("reset_rd_b", rdd_b, 0);
      chk("reset_busy_a", busy_a, 0); chk("reset_busy_b", busy_b, 0);
    end
    chk("reset_nzp", nzp, 3'b010);
    chk("reset_err", wr_err, 0);
    chk("reset_dbg", dbg_data, 0);

    // Directed table
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rsv_valid = tbl[i].rv; rsv_addr = tbl[i].ra;
      wr_valid = tbl[i].wv; wr_addr = tbl[i].wa; wr_data = tbl[i].wd; wr_setcc = tbl[i].sc;
      rd_a = tbl[i].rda; rd_b = tbl[i].rda; dbg_addr = tbl[i].dbg;
      #1;
      chk($sformatf("tbl%0d_rd_a", i), rdd_a, tbl[i].e_rd);
      chk($sformatf("tbl%0d_rd_b", i), rdd_b, tbl[i].e_rd);
      chk($sformatf("tbl%0d_busy_a", i), busy_a, tbl[i].e_busy);
      chk($sformatf("tbl%0d_busy_b", i), busy_b, tbl[i].e_busy);
      chk($sformatf("tbl%0d_rsv_ready", i), rsv_ready, tbl[i].e_rdy);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_nzp", i), nzp, tbl[i].e_nzp);
      chk($sformatf("tbl%0d_err", i), wr_err, tbl[i].e_err);
      chk($sformatf("tbl%0d_dbg", i), dbg_data, tbl[i].e_dbg);
    end

    // Reset mid-operation with R4, R6 reserved and a write presented
    @(negedge clk); idle(); rsv_valid = 1; rsv_addr = 3'd4;
    @(negedge clk); rsv_addr = 3'd6;
    @(negedge clk); idle();
    rd_a = 3'd4; rd_b = 3'd6; #1;
    chk("pre_rst_busy4", busy_a, 1); chk("pre_rst_busy6", busy_b, 1);
    wr_valid = 1; wr_addr = 3'd4; wr_data = 16'hFFFF; wr_setcc = 1;
    rd_a = 3'd6; rd_b = 3'd1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_busy6", busy_a, 0);
    chk("rst_async_r1", rdd_b, 0);
    chk("rst_async_err", wr_err, 0);
    chk("rst_async_nzp", nzp, 3'b010);
    repeat (2) @(posedge clk);
    @(negedge clk); idle(); rst_n = 1'b1;
    rd_a = 3'd4; rd_b = 3'd6; rsv_addr = 3'd6; dbg_addr = 3'd4;
    #1;
    chk("post_rst_r4", rdd_a, 0);
    chk("post_rst_busy4", busy_a, 0);
    chk("post_rst_busy6", busy_b, 0);
    chk("post_rst_ready6", rsv_ready, 1);
    chk("post_rst_nzp", nzp, 3'b010);
    @(posedge clk); #1;
    chk("post_rst_dbg4", dbg_data, 0);
    chk("post_rst_err", wr_err, 0);

    // Randomized run against the model
    model_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rsv_valid = ($urandom_range(0, 1) == 1);
      rsv_addr  = AW'($urandom_range(0, NR-1));
      wr_valid  = ($urandom_range(0, 1) == 1);
      wr_addr   = AW'($urandom_range(0, NR-1));
      if ($urandom_range(0, 4) != 0) begin
        // bias toward reserved registers
        for (int k = 0; k < NR; k++) begin
          int j;
          j = (int'(wr_addr) + k) % NR;
          if (m_busy[j]) begin wr_addr = AW'(j); break; end
        end
      end
      case ($urandom_range(0, 3))
        0:       wr_data = 16'h0000;
        1:       wr_data = 16'h8000 | 16'($urandom);
        default: wr_data = 16'($urandom);
      endcase
      wr_setcc = ($urandom_range(0, 1) == 1);
      rd_a = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom_range(0, NR-1));
      rd_b = ($urandom_range(0, 2) == 0) ? rsv_addr : AW'($urandom_range(0, NR-1));
      dbg_addr = AW'($urandom_range(0, NR-1));
      #1;
      chk("rnd_rd_a", rdd_a, exp_rd(rd_a));
      chk("rnd_rd_b", rdd_b, exp_rd(rd_b));
      chk("rnd_busy_a", busy_a, exp_busy(rd_a));
      chk("rnd_busy_b", busy_b, exp_busy(rd_b));
      chk("rnd_ready", rsv_ready, exp_ready());
      model_edge();
      @(posedge clk); #1;
      chk("rnd_nzp", nzp, m_nzp);
      chk("rnd_err", wr_err, m_err);
      chk("rnd_dbg", dbg_data, m_dbg);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc3_regfile_sb.md
LC3_REGFILE_SB -- requirements
Module: lc3_regfile_sb

Interface
REQ-001 Parameter DATA_W, 16, register width in bits.
REQ-002 Parameter NUM_REGS, 8, number of general registers (2..32).
REQ-003 Parameter BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports.
REQ-004 Localparam ADDR_W, $clog2(NUM_REGS), register address width.
REQ-005 One clock and one asynchronous, active-low reset: clock  in  1  rising-edge clock; reset_n  in  1  async active-low reset.
REQ-006 rd_addr_a, rd_addr_b  in  ADDR_W  source register addresses.
REQ-007 rd_data_a, rd_data_b  out  DATA_W  source register values, combinational.
REQ-008 rd_busy_a, rd_busy_b  out  1  source register has a pending reservation.
REQ-009 rsv_valid  in  1  request to reserve a destination register.
REQ-010 rsv_addr  in  ADDR_W  destination register to reserve.
REQ-011 rsv_ready  out  1  reservation accepted this cycle.
REQ-012 wr_valid  in  1  write-back strobe.
REQ-013 wr_addr  in  ADDR_W  write-back register; wr_data  in  DATA_W  write-back value.
REQ-014 wr_setcc  in  1  write-back also updates condition codes.
REQ-015 nzp  out  3  condition codes {N,Z,P}, registered.
REQ-016 wr_err  out  1  sticky flag: write to an unreserved register.
REQ-017 dbg_addr  in  ADDR_W; dbg_data  out  DATA_W  registered debug read, 1-cycle latency.

Function
REQ-018 Register write SHALL occur on the rising clock edge when wr_valid=1 and wr_addr<NUM_REGS; writes to addr>=NUM_REGS are ignored.
REQ-019 rd_data_x SHALL equal regs[rd_addr_x]; if BYPASS=1, wr_valid=1 and wr_addr=rd_addr_x, it SHALL equal wr_data instead; addr>=NUM_REGS reads 0.
REQ-020 Scoreboard: one busy bit per register; busy set at the edge where rsv_valid&&rsv_ready, cleared at the edge where wr_valid writes that register.
REQ-021 rsv_ready SHALL be 1 when rsv_addr<NUM_REGS and (busy[rsv_addr]=0 or wr_valid&&wr_addr=rsv_addr), else 0; combinational.
REQ-022 Simultaneous reservation and write-back to the same register: data written, busy remains set (new reservation wins).
REQ-023 rd_busy_x SHALL equal busy[rd_addr_x], except it reads 0 when a write-back to that register happens in the same cycle and no reservation of it is accepted that cycle.
REQ-024 nzp update at the write edge when wr_valid&&wr_setcc: 3'b100 if wr_data[DATA_W-1]=1, 3'b010 if wr_data=0, else 3'b001; otherwise hold.
REQ-025 wr_err SHALL set at the edge where wr_valid=1 and busy[wr_addr]=0; the write still occurs; cleared only by reset.
REQ-026 dbg_data SHALL be regs[dbg_addr] sampled at the clock edge (post-write value is not visible until the following edge).
REQ-027 No timing delays or blocking writes on register state; all state updates in one clocked process.

Reset
REQ-028 reset_n=0 SHALL asynchronously clear all registers to 0, all busy bits to 0, nzp to 3'b010, wr_err to 0, dbg_data to 0.
REQ-029 Reset asserted mid-operation SHALL drop all pending reservations; write-backs presented while reset_n=0 are discarded.

Structure
REQ-030 Shared package lc3_pkg SHALL hold the nzp encodings (NZP_N, NZP_Z, NZP_P, NZP_RESET) and the default DATA_W.
REQ-031 Sub-module lc3_scoreboard (busy bits, rsv_ready, rd_busy logic) SHALL be instantiated once; data array and nzp stay in the top.

Verification
REQ-032 Reset, then read all addresses -> rd_data=0, rd_busy=0, nzp=3'b010, wr_err=0.
REQ-033 Reserve R3, next cycle write R3=16'h8001 with wr_setcc=1 -> busy[3] cleared, nzp=3'b100, rd_data_a(R3)=16'h8001, wr_err=0.
REQ-034 Reserve R2, then in the write cycle read R2 with BYPASS=1, wr_data=16'h0000, wr_setcc=1 -> rd_data_a=0 same cycle, rd_busy_a=0, nzp=3'b010 after edge.
REQ-035 R5 busy, rsv_valid on R5 without write -> rsv_ready=0; same cycle as write to R5 -> rsv_ready=1, busy[5] stays 1.
REQ-036 Write R1=16'h0007 with R1 unreserved -> R1=7, nzp unchanged if wr_setcc=0, wr_err=1 sticky until reset.
REQ-037 Assert reset_n=0 with R4 and R6 reserved mid-sequence -> all busy 0 immediately, registers 0, write presented during reset ignored.
